// File: rtl/aes_mixcolumns_iter.sv
// Iterative AES MixColumns / InvMixColumns over a 128-bit state, COLS_PER_CYCLE columns per busy cycle.
// Optional inverse transform enabled by defining AES_INV_MIXCOLUMNS_EN.
module aes_mixcolumns_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned IDX_W   = 2;
  localparam int          N_LANES = int'(COLS_PER_CYCLE);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t               r_fsm;
  logic [STATE_W-1:0] r_state;
  logic [IDX_W-1:0]   r_idx;
  logic               r_out_valid;
  logic [STATE_W-1:0] w_next_state;
  logic               w_last;

  // Multiply by x in GF(2^8) modulo 0x11b
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [COL_W-1:0] mix_fwd(input logic [COL_W-1:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;
    a0 = col[31:24]; a1 = col[23:16]; a2 = col[15:8]; a3 = col[7:0];
    d0 = xt(a0); d1 = xt(a1); d2 = xt(a2); d3 = xt(a3);
    return {d0 ^ d1 ^ a1 ^ a2 ^ a3,
            a0 ^ d1 ^ d2 ^ a2 ^ a3,
            a0 ^ a1 ^ d2 ^ d3 ^ a3,
            d0 ^ a0 ^ a1 ^ a2 ^ d3};
  endfunction

`ifdef AES_INV_MIXCOLUMNS_EN
  logic r_inv;

  // Coefficients 0e/0b/0d/09 built from x, x^2, x^3 multiples of each byte
  function automatic logic [COL_W-1:0] mix_inv(input logic [COL_W-1:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    a[0] = col[31:24]; a[1] = col[23:16]; a[2] = col[15:8]; a[3] = col[7:0];
    for (int i = 0; i < 4; i++) begin
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`else
  logic w_unused_inv;
  assign w_unused_inv = in_inv;
`endif

  // Rewrite the lanes starting at the current column index, leave the rest untouched
  always_comb begin
    w_next_state = r_state;
    for (int k = 0; k < N_LANES; k++) begin
`ifdef AES_INV_MIXCOLUMNS_EN
      w_next_state[127 - 32*(int'(r_idx) + k) -: 32] = r_inv ?
          mix_inv(r_state[127 - 32*(int'(r_idx) + k) -: 32]) :
          mix_fwd(r_state[127 - 32*(int'(r_idx) + k) -: 32]);
`else
      w_next_state[127 - 32*(int'(r_idx) + k) -: 32] =
          mix_fwd(r_state[127 - 32*(int'(r_idx) + k) -: 32]);
`endif
    end
  end

  assign w_last = (r_idx == IDX_W'(4 - COLS_PER_CYCLE));

  // DONE lets a new state in on the same edge the result is retired
  assign in_ready  = (r_fsm == IDLE) || ((r_fsm == DONE) && out_ready);
  assign out_valid = r_out_valid;
  assign out_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_state     <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
`ifdef AES_INV_MIXCOLUMNS_EN
      r_inv       <= 1'b0;
`endif
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= in_state;
            r_idx   <= '0;
`ifdef AES_INV_MIXCOLUMNS_EN
            r_inv   <= in_inv;
`endif
            r_fsm   <= BUSY;
          end
        end
        BUSY: begin
          r_state <= w_next_state;
          r_idx   <= r_idx + IDX_W'(COLS_PER_CYCLE);
          if (w_last) begin
            r_fsm       <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_state <= in_state;
              r_idx   <= '0;
`ifdef AES_INV_MIXCOLUMNS_EN
              r_inv   <= in_inv;
`endif
              r_fsm   <= BUSY;
            end else begin
              r_fsm <= IDLE;
            end
          end
        end
        default: begin
          r_fsm       <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_mixcolumns_iter.md
AES_MIXCOLUMNS_ITER -- requirements
Module: aes_mixcolumns_iter

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1: columns transformed per busy cycle; legal values 1, 2, 4; any other value is a compile-time error.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: in_state and in_inv are presented.
REQ-005 SHALL have port in_ready, output, 1: block accepts a state this cycle.
REQ-006 SHALL have port in_state, input, 128: AES state, column-major; s0 = [127:120] ... s15 = [7:0]; column c = bytes s(4c)..s(4c+3), row 0 first.
REQ-007 SHALL have port in_inv, input, 1: 1 selects InvMixColumns, 0 selects MixColumns.
REQ-008 SHALL have port out_valid, output, 1: out_state holds a result.
REQ-009 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-010 SHALL have port out_state, output, 128: transformed state, same byte order as in_state.

Function
REQ-011 SHALL implement FSM IDLE, BUSY, DONE.
REQ-012 IDLE: in_ready=1; on in_valid, SHALL capture in_state and in_inv, clear the column index, and go to BUSY.
REQ-013 BUSY: each cycle SHALL transform COLS_PER_CYCLE columns in place, lowest-index columns first, and advance the index by COLS_PER_CYCLE; after 4/COLS_PER_CYCLE cycles SHALL go to DONE.
REQ-014 Latency SHALL be accept edge to out_valid=1 after 4/COLS_PER_CYCLE + 1 edges: 5, 3 or 2.
REQ-015 Forward coefficients SHALL be the circulant {02,03,01,01}; inverse coefficients SHALL be {0e,0b,0d,09}. GF(2^8) arithmetic SHALL use reduction polynomial 0x11b.
REQ-016 DONE: out_valid=1 and out_state SHALL stay stable until out_ready=1.
REQ-017 In DONE, in_ready SHALL equal out_ready; when in_valid and out_ready are both 1, the result SHALL be retired and the new state captured on the same edge, going directly to BUSY with no bubble.
REQ-018 In DONE with out_ready=1 and in_valid=0, the FSM SHALL go to IDLE.
REQ-019 in_ready SHALL be 0 in BUSY; in_valid in BUSY SHALL be ignored and SHALL NOT alter state.
REQ-020 Captured in_inv SHALL govern the entire operation; later changes on in_inv SHALL have no effect.
REQ-021 out_state SHALL be driven from the working register and is valid only while out_valid=1.

Reset
REQ-022 rst=1 at any edge, including mid-BUSY or in DONE, SHALL force IDLE, column index 0, out_valid=0, and working register 128'h0; the in-flight state is discarded.
REQ-023 After reset, in_ready SHALL be 1 on the first cycle in which rst=0.
REQ-024 rst SHALL take priority over every handshake on the same edge.

Configuration
REQ-025 With macro AES_INV_MIXCOLUMNS_EN defined, in_inv SHALL select the inverse transform per REQ-007.
REQ-026 Without AES_INV_MIXCOLUMNS_EN, inverse multipliers SHALL be absent, in_inv SHALL be ignored, and only forward MixColumns SHALL be performed.

Verification
REQ-027 Forward, COLS_PER_CYCLE=1: column 0 = db 13 53 45, column 1 = f2 0a 22 5c, column 2 = 01 01 01 01, column 3 = c6 c6 c6 c6 -> out columns 8e 4d a1 bc, 9f dc 58 9d, 01 01 01 01, c6 c6 c6 c6; out_valid on edge 5.
REQ-028 Forward, COLS_PER_CYCLE=4: columns d4 d4 d4 d5, 2d 26 31 4c, db 13 53 45, 01 01 01 01 -> d5 d5 d7 d6, 4d 7e bd f8, 8e 4d a1 bc, 01 01 01 01; out_valid on edge 2.
REQ-029 Inverse, macro defined, in_inv=1: the REQ-027 output fed back SHALL return the REQ-027 input; in_inv toggled during BUSY SHALL leave the result unchanged.
REQ-030 Backpressure: out_ready=0 for 10 cycles in DONE -> out_state stable and in_ready=0; then out_ready=1 with in_valid=1 -> new state captured on the same edge, BUSY next cycle.
REQ-031 Reset at the second BUSY cycle -> next cycle IDLE, out_valid=0, in_ready=1; a fresh operation then completes correctly.
REQ-032 Macro undefined: in_inv=1 with REQ-027 input -> REQ-027 forward output.
